// File: rtl/serial_add_sub_if.sv
// ---------------------------------------------------------------------------
// serial_add_sub_if
// Request/result bundle for the bit-serial adder/subtractor.
//   start  : request pulse, sampled only while busy=0
//   sub    : 0 = a+b, 1 = a-b (sampled with start)
//   a, b   : WIDTH-bit operands (sampled with start)
//   busy   : operation in progress
//   done   : one-cycle pulse, result/c_out/ovf just updated
//   result : sum/difference modulo 2^WIDTH
//   c_out  : final carry (for sub: 1 = no borrow)
//   ovf    : signed two's-complement overflow
// master drives the request side, slave (the adder) drives the result side.
// ---------------------------------------------------------------------------
interface serial_add_sub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             c_out;
   logic             ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, result, c_out, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, result, c_out, ovf
   );
endinterface

// File: rtl/serial_add_sub.sv
// ---------------------------------------------------------------------------
// serial_add_sub
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, one bit
// per clock, LSB first. A start accepted in IDLE latches the operands; the
// result, carry and signed overflow are published WIDTH edges later together
// with a one-cycle done pulse.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : serial_add_sub_if slave (start/sub/a/b in; busy/done/result/c_out/ovf out)
// ---------------------------------------------------------------------------
module serial_add_sub #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   serial_add_sub_if.slave   bus
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [WIDTH-1:0] r_acc;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;
   logic [WIDTH-1:0] r_result;
   logic             r_c_out;
   logic             r_ovf;

   logic             w_accept;
   logic             w_last;
   logic             w_sum;
   logic             w_carry_nxt;

   assign w_accept = (r_state == IDLE) && bus.start;
   assign w_last   = (r_state == RUN) && (r_cnt == LAST_BIT);

   // The single full-adder cell working on the current LSBs.
   assign w_sum       = r_op_a[0] ^ r_op_b[0] ^ r_carry;
   assign w_carry_nxt = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) |
                        (r_op_b[0] & r_carry);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_nxt = RUN;
         RUN:     if (r_cnt == LAST_BIT) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs: busy follows the state; the rest come from registers.
   always_comb begin
      bus.busy   = (r_state == RUN);
      bus.done   = r_done;
      bus.result = r_result;
      bus.c_out  = r_c_out;
      bus.ovf    = r_ovf;
   end

   // Datapath: operand shift registers, carry, accumulator, published results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_acc    <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_c_out  <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            r_op_a  <= bus.a;
            r_op_b  <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub;
            r_cnt   <= '0;
         end else if (r_state == RUN) begin
            r_op_a  <= r_op_a >> 1;
            r_op_b  <= r_op_b >> 1;
            r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
            r_carry <= w_carry_nxt;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
               // On the MSB, r_carry is the carry into the sign bit and
               // w_carry_nxt the carry out; they differ on signed overflow.
               r_result <= {w_sum, r_acc[WIDTH-1:1]};
               r_c_out  <= w_carry_nxt;
               r_ovf    <= r_carry ^ w_carry_nxt;
               r_done   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_add_sub
// Self-checking bench for serial_add_sub (WIDTH=8): directed cases plus
// randomized operations against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_serial_add_sub;

   localparam int W = 8;

   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;
   logic [W-1:0] last_res;
   logic         last_c;
   logic         last_o;

   serial_add_sub_if #(.WIDTH(W)) bus ();

   serial_add_sub #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic. Returns {ovf, c_out, result}.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
      int full;
      int sv;
      logic [W-1:0] r;
      logic c;
      logic o;
      if (s) full = int'(x) + (256 - int'(y));
      else   full = int'(x) + int'(y);
      r = full[W-1:0];
      c = (full >= 256);
      if (s) sv = int'($signed(x)) - int'($signed(y));
      else   sv = int'($signed(x)) + int'($signed(y));
      o = (sv > 127) || (sv < -128);
      return {o, c, r};
   endfunction

   // Called at #1 after a rising edge with busy=0. Issues one operation,
   // follows it to its done pulse and checks the outcome. Returns with the
   // time at #1 after the done edge.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tsub, input bit inject);
      logic [W+1:0] e;
      int lat;
      e = model(ta, tb_v, tsub);
      bus.start = 1'b1;
      bus.a     = ta;
      bus.b     = tb_v;
      bus.sub   = tsub;
      @(posedge clk); #1;
      bus.start = 1'b0;
      // Operands are scrambled after the start edge; only latched copies count.
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      bus.sub = 1'($urandom);
      chk("busy_at_start", {31'd0, bus.busy}, 32'd1);
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         if (inject && i == 3) begin
            bus.start = 1'b1;
            bus.a     = 8'hAA;
         end
         @(posedge clk); #1;
         if (inject && i == 3) bus.start = 1'b0;
         if (bus.done) begin
            lat = i;
            break;
         end
         if (i == 4) begin
            chk("busy_mid", {31'd0, bus.busy}, 32'd1);
            chk("result_held", {24'd0, bus.result}, {24'd0, last_res});
            chk("cout_held", {31'd0, bus.c_out}, {31'd0, last_c});
            chk("ovf_held", {31'd0, bus.ovf}, {31'd0, last_o});
         end
      end
      chk("latency", lat, W);
      chk("result", {24'd0, bus.result}, {24'd0, e[W-1:0]});
      chk("c_out", {31'd0, bus.c_out}, {31'd0, e[W]});
      chk("ovf", {31'd0, bus.ovf}, {31'd0, e[W+1]});
      chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
      last_res = e[W-1:0];
      last_c   = e[W];
      last_o   = e[W+1];
   endtask

   task automatic idle_edge();
      @(posedge clk); #1;
      chk("done_low", {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      n_total   = 0;
      n_bad     = 0;
      last_res  = '0;
      last_c    = 1'b0;
      last_o    = 1'b0;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      rst       = 1'b0;

      // Asynchronous reset before any clock edge.
      #1 rst = 1'b1;
      #1;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_result", {24'd0, bus.result}, 32'd0);
      chk("rst_cout", {31'd0, bus.c_out}, 32'd0);
      chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed arithmetic cases.
      run_op(8'h05, 8'h03, 1'b0, 1'b0); idle_edge();
      run_op(8'hFF, 8'h01, 1'b0, 1'b0); idle_edge();
      run_op(8'h7F, 8'h01, 1'b0, 1'b0); idle_edge();
      run_op(8'h03, 8'h05, 1'b1, 1'b0); idle_edge();
      run_op(8'h80, 8'h01, 1'b1, 1'b0); idle_edge();
      run_op(8'h00, 8'h00, 1'b1, 1'b0); idle_edge();

      // Start while busy is ignored; start on the done cycle is accepted.
      run_op(8'h01, 8'h01, 1'b0, 1'b1);
      run_op(8'h10, 8'h20, 1'b0, 1'b0); idle_edge();

      // Reset mid-operation aborts with no done pulse.
      bus.start = 1'b1;
      bus.a     = 8'h0F;
      bus.b     = 8'h01;
      bus.sub   = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_done", {31'd0, bus.done}, 32'd0);
      chk("abort_result", {24'd0, bus.result}, 32'd0);
      chk("abort_cout", {31'd0, bus.c_out}, 32'd0);
      chk("abort_ovf", {31'd0, bus.ovf}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      last_res = '0;
      last_c   = 1'b0;
      last_o   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("abort_no_done", {31'd0, bus.done}, 32'd0);
      end
      run_op(8'h0F, 8'h01, 1'b0, 1'b0); idle_edge();

      // Randomized operations, some back-to-back on the done cycle.
      for (int n = 0; n < 40; n++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 1) == 0) idle_edge();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
